instr_fetch: RTL and testbench

Fetch stage directly upstream of the instruction ROM. Owns the program counter, drives the 8-bit ROM address, and captures the 16-bit instruction word into an instruction register (IR) with a valid/ready handshake to the decoder. Accepts redirects from execute for taken branches and jumps, with a one-bubble penalty.

---
 rtl/instr_fetch.sv | 52 +++++
 tb/tb_instr_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and instruction register with valid/ready handoff to decode
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc
);
    typedef enum logic [1:0] {IDLE, RUN, STALL, REDIRECT} state_t;
    state_t state;
    logic load;
    assign rom_addr = pc;
    // REDIRECT behaves like RUN; ir_valid is always 0 there, so it always loads when enabled
    always_comb
        load = !redirect_valid && fetch_en &&
               ((state == RUN || state == REDIRECT) ? (!ir_valid || ir_ready) :
                (state == STALL && ir_ready));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            state    <= IDLE;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
            state    <= REDIRECT;
        end else if (load) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 1'b1;
            state    <= RUN;
        end else begin
            if (ir_ready)
                ir_valid <= 1'b0;
            state <= (!fetch_en && (state != STALL || ir_ready)) ? IDLE :
                     (state == IDLE) ? RUN : STALL;
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a transaction-level model
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        fetch_en = 0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready = 0;
    logic        redirect_valid = 0;
    logic [7:0]  redirect_pc = 0;
    logic [7:0]  pc;
    logic [15:0] rom [256];
    int checks = 0, errors = 0;

    instr_fetch dut (.clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc));

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    // Model: a fetcher that is either cold (needs a warm-up edge), running, or stalled on a held word
    logic [7:0]  m_pc = 0;
    bit          m_vld = 0, m_warm = 0, m_stalled = 0;
    logic [23:0] q [$];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pc = 0; m_vld = 0; m_warm = 0; m_stalled = 0; q.delete();
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_vld = 0; m_warm = 1; m_stalled = 0; q.delete();
        end else if (!m_warm) begin
            if (ir_ready) m_vld = 0;
            m_warm = fetch_en;
        end else if (m_stalled && !ir_ready) begin
        end else if (m_vld && !ir_ready && fetch_en) begin
            m_stalled = 1;
        end else if (!fetch_en) begin
            if (ir_ready) m_vld = 0;
            m_warm = 0; m_stalled = 0;
        end else begin
            q.push_back({rom[m_pc], m_pc});
            m_vld = 1; m_stalled = 0;
            m_pc = m_pc + 8'd1;
        end

    always @(negedge clk) begin
        logic [23:0] e;
        if (!rst_n) begin
            chk("rst_pc", {16'h0, pc}, 24'h0);
            chk("rst_ir", {ir, ir_pc}, 24'h0);
            chk("rst_valid", {23'h0, ir_valid}, 24'h0);
        end else begin
            chk("pc", {16'h0, pc}, {16'h0, m_pc});
            chk("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
            chk("ir_valid", {23'h0, ir_valid}, {23'h0, m_vld});
            if (ir_valid && ir_ready && !redirect_valid) begin
                if (q.size() == 0) chk("xfer_unexpected", {ir, ir_pc}, 24'hxxxxxx);
                else begin
                    e = q.pop_front();
                    chk("xfer", {ir, ir_pc}, e);
                end
            end
        end
    end

    task automatic cyc(input bit f, input bit r, input bit v, input logic [7:0] t);
        fetch_en = f; ir_ready = r; redirect_valid = v; redirect_pc = t;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h00] = 16'hC000; rom[8'h01] = 16'hC801;
        rom[8'h09] = 16'h6898; rom[8'hFF] = 16'h9800;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'h09); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'h0F); cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'h00); repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'hFE); repeat (5) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'h05); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 8'h20); repeat (3) cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 8'h35);
        for (int i = 0; i < 10 && m_pc != 8'h37; i++) cyc(1, 1, 0, 0);
        @(negedge clk); #2 rst_n = 0; #1;
        chk("async_pc", {16'h0, pc}, 24'h0);
        chk("async_valid", {23'h0, ir_valid}, 24'h0);
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #1;
        repeat (4) cyc(1, 1, 0, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 11) == 0, 8'($urandom));
        cyc(1, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
